// File: rtl/quartsine_phase_gen.sv
// quartsine_phase_gen: sample-rate tick, tuned phase accumulator and
// quarter-wave LUT addressing. The registered ROM output is rebuilt into an
// unsigned full-wave magnitude centred on midscale for the PWM stage.
//
// Output handshake: sample_valid is a one-clock strobe with no ready. In the
// cycle it is high, magnitude, lut_addr, phasesw and invert all describe the
// same sample. Between strobes every output holds its value. No back-pressure
// exists; the consumer must take the sample in the strobe cycle.
module quartsine_phase_gen #(
  parameter int ACC_W      = 16,
  parameter int ADDR_W     = 8,
  parameter int MAG_W      = 11,
  parameter int TUNE_SHIFT = 4,
  parameter int SAMPLE_DIV = 1134
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [7:0]        tune,
  output logic [ADDR_W-1:0] lut_addr,
  input  logic [MAG_W-2:0]  lut_data,
  output logic              phasesw,
  output logic              invert,
  output logic [MAG_W-1:0]  magnitude,
  output logic              sample_valid
);

  // Counter sized to hold SAMPLE_DIV-1.
  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  // Midscale and midscale-1: the positive half-wave is built upward from MID,
  // the negative half-wave downward from MID_M1, so the two halves never
  // share a code and the result always fits in MAG_W bits.
  localparam logic [MAG_W-1:0] MID    = {1'b1, {(MAG_W-1){1'b0}}};
  localparam logic [MAG_W-1:0] MID_M1 = {1'b0, {(MAG_W-1){1'b1}}};

  // The three pipeline stages after a tick must drain before the next tick,
  // otherwise stage valids and the invert delay register would be overwritten.
  if (SAMPLE_DIV < 4) begin : g_div_check
    $error("quartsine_phase_gen: SAMPLE_DIV must be >= 4");
  end

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ADDR_W-1:0] lut_addr_q, lut_addr_d;
  logic              phasesw_q, phasesw_d;
  logic              invert_q, invert_d;
  logic              inv_dly_q, inv_dly_d;
  logic [MAG_W-1:0]  magnitude_q, magnitude_d;
  logic              sample_valid_q, sample_valid_d;

  // Stage valids: s1 = address presented to ROM, s2 = ROM data available.
  logic              s1_vld_q, s1_vld_d;
  logic              s2_vld_q, s2_vld_d;

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  logic              tick;
  logic [ACC_W-1:0]  step;
  logic [ACC_W-1:0]  acc_next;
  logic [1:0]        quad;
  logic [ADDR_W-1:0] idx;
  logic [MAG_W-1:0]  q_ext;

  // Sample-rate counter: advances only while enabled, ticks on its last count.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (en) begin
      if (cnt_q == CNT_LAST) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Phase step and quadrant decode taken from the post-increment phase.
  always_comb begin
    step     = ACC_W'(tune) << TUNE_SHIFT;
    acc_next = acc_q + step;
    quad     = acc_next[ACC_W-1 -: 2];
    idx      = acc_next[ACC_W-3 -: ADDR_W];
  end

  // Tick stage: advance the phase and register the quarter-table address.
  // Odd quadrants run the table backwards, so the index is mirrored there.
  always_comb begin
    acc_d      = acc_q;
    lut_addr_d = lut_addr_q;
    phasesw_d  = phasesw_q;
    invert_d   = invert_q;
    s1_vld_d   = 1'b0;
    if (tick) begin
      acc_d      = acc_next;
      phasesw_d  = quad[0];
      invert_d   = quad[1];
      lut_addr_d = quad[0] ? ~idx : idx;
      s1_vld_d   = 1'b1;
    end
  end

  // ROM-read stage: carry invert alongside the ROM's one-cycle latency so
  // the sign used for reconstruction matches the data coming back.
  always_comb begin
    inv_dly_d = inv_dly_q;
    s2_vld_d  = s1_vld_q;
    if (s1_vld_q) begin
      inv_dly_d = invert_q;
    end
  end

  // Reconstruction stage: fold the quarter-wave value into a full-wave code.
  always_comb begin
    q_ext          = {1'b0, lut_data};
    magnitude_d    = magnitude_q;
    sample_valid_d = s2_vld_q;
    if (s2_vld_q) begin
      magnitude_d = inv_dly_q ? (MID_M1 - q_ext) : (MID + q_ext);
    end
  end

  // State register; reset cancels every in-flight stage and parks at midscale.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      acc_q          <= '0;
      lut_addr_q     <= '0;
      phasesw_q      <= 1'b0;
      invert_q       <= 1'b0;
      inv_dly_q      <= 1'b0;
      magnitude_q    <= MID;
      sample_valid_q <= 1'b0;
      s1_vld_q       <= 1'b0;
      s2_vld_q       <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      lut_addr_q     <= lut_addr_d;
      phasesw_q      <= phasesw_d;
      invert_q       <= invert_d;
      inv_dly_q      <= inv_dly_d;
      magnitude_q    <= magnitude_d;
      sample_valid_q <= sample_valid_d;
      s1_vld_q       <= s1_vld_d;
      s2_vld_q       <= s2_vld_d;
    end
  end

  assign lut_addr     = lut_addr_q;
  assign phasesw      = phasesw_q;
  assign invert       = invert_q;
  assign magnitude    = magnitude_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_quartsine_phase_gen.sv
// Bench for quartsine_phase_gen with a short sample period (4 clk) and a
// linear ROM model q = addr*4.
module tb_quartsine_phase_gen;

  localparam int SDIV = 4;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] tune;
  logic [7:0] lut_addr;
  logic [9:0] lut_data;
  logic       phasesw;
  logic       invert;
  logic [10:0] magnitude;
  logic       sample_valid;

  always #5 clk = ~clk;

  quartsine_phase_gen #(
    .ACC_W(16), .ADDR_W(8), .MAG_W(11), .TUNE_SHIFT(4), .SAMPLE_DIV(SDIV)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .tune(tune),
    .lut_addr(lut_addr), .lut_data(lut_data),
    .phasesw(phasesw), .invert(invert),
    .magnitude(magnitude), .sample_valid(sample_valid)
  );

  // Synchronous ROM: data one clock after the address, q = addr*4.
  always_ff @(posedge clk) lut_data <= {lut_addr, 2'b00};

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] due;
    logic        inv;
    logic        ps;
    logic [7:0]  addr;
    logic [10:0] mag;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic [EW-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference model: tick counter and phase accumulator, evaluated on each
  // rising edge from the inputs the DUT sees on that edge. A tick in cycle c
  // produces a strobe in cycle c+3.
  int          m_cnt = 0;
  logic [15:0] m_acc = '0;
  exp_t        m_e;
  logic [9:0]  m_q;
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_cnt = 0;
      m_acc = '0;
      exp_q.delete();
    end else if (en) begin
      if (m_cnt == SDIV - 1) begin
        m_acc    = m_acc + ({8'h00, tune} << 4);
        m_e.ps   = m_acc[14];
        m_e.inv  = m_acc[15];
        m_e.addr = m_acc[14] ? ~m_acc[13:6] : m_acc[13:6];
        m_q      = {m_e.addr, 2'b00};
        m_e.mag  = m_e.inv ? (11'd1023 - {1'b0, m_q}) : (11'd1024 + {1'b0, m_q});
        m_e.due  = cyc + 3;
        exp_q.push_back(m_e);
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    cyc++;
  end

  // Monitor: every strobe must match the oldest expected sample in time and value.
  exp_t k_e;
  initial forever begin
    @(negedge clk);
    if (sample_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_strobe", 32'(sample_valid), 32'd0);
      end else begin
        k_e = exp_q.pop_front();
        check("sv_cycle", 32'(cyc), k_e.due);
        check("sv_mag", 32'(magnitude), 32'(k_e.mag));
        check("sv_addr", 32'(lut_addr), 32'(k_e.addr));
        check("sv_phasesw", 32'(phasesw), 32'(k_e.ps));
        check("sv_invert", 32'(invert), 32'(k_e.inv));
      end
    end else if (exp_q.size() > 0) begin
      k_e = exp_q[0];
      if (k_e.due <= cyc) begin
        check("missed_strobe", 32'(sample_valid), 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_strobe(input int max_cyc, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (sample_valid !== 1'b1 && waited < max_cyc);
    check("strobe_timeout", 32'(sample_valid), 32'd1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int w;
  int nsv;
  logic [7:0] h_addr;
  logic       h_ps, h_inv;

  initial begin
    rst = 1'b1; en = 1'b1; tune = 8'd4;

    // 1. reset values, then first tick SDIV-1 cycles after release
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(lut_addr), 32'd0);
    check("rst_phasesw", 32'(phasesw), 32'd0);
    check("rst_invert", 32'(invert), 32'd0);
    check("rst_mag", 32'(magnitude), 32'd1024);
    check("rst_sv", 32'(sample_valid), 32'd0);
    rst = 1'b0;
    wait_strobe(20, w);
    check("first_latency", 32'(w), 32'(SDIV - 1 + 3));

    // 2. ramp: step 64 -> addr 1,2,3 and magnitude 1028,1032,1036
    check("ramp1_mag", 32'(magnitude), 32'd1028);
    check("ramp1_addr", 32'(lut_addr), 32'd1);
    for (int k = 2; k <= 3; k++) begin
      wait_strobe(20, w);
      check("ramp_period", 32'(w), 32'(SDIV));
      check("ramp_mag", 32'(magnitude), 32'(1024 + 4 * k));
      check("ramp_addr", 32'(lut_addr), 32'(k));
    end

    // 3. quadrants: step 1024, one full cycle in 64 ticks
    tune = 8'd64;
    do_reset(2);
    for (int k = 1; k <= 64; k++) begin
      wait_strobe(20, w);
      if (k == 16) begin
        check("q16_phasesw", 32'(phasesw), 32'd1);
        check("q16_addr", 32'(lut_addr), 32'd255);
        check("q16_invert", 32'(invert), 32'd0);
      end
      if (k == 32) begin
        check("q32_invert", 32'(invert), 32'd1);
        check("q32_phasesw", 32'(phasesw), 32'd0);
        check("q32_addr", 32'(lut_addr), 32'd0);
        check("q32_mag", 32'(magnitude), 32'd1023);
      end
      if (k == 48) begin
        check("q48_mag", 32'(magnitude), 32'd3);
      end
      if (k == 64) begin
        check("q64_invert", 32'(invert), 32'd0);
        check("q64_phasesw", 32'(phasesw), 32'd0);
        check("q64_addr", 32'(lut_addr), 32'd0);
        check("q64_mag", 32'(magnitude), 32'd1024);
      end
    end

    // 4. enable gating: strobe is in cycle X+3, tick in X+4, counter is 1 in
    //    X+6. Dropping en there freezes the count at 1 with a strobe in flight.
    repeat (3) @(negedge clk);
    en = 1'b0;
    h_addr = lut_addr; h_ps = phasesw; h_inv = invert;
    nsv = 0;
    repeat (10) begin
      @(negedge clk);
      if (sample_valid === 1'b1) nsv++;
    end
    check("gate_strobes", 32'(nsv), 32'd1);
    check("gate_addr_hold", 32'(lut_addr), 32'(h_addr));
    check("gate_ps_hold", 32'(phasesw), 32'(h_ps));
    check("gate_inv_hold", 32'(invert), 32'(h_inv));
    // Count held at 1: SDIV-1-1 more enabled cycles to the tick, then 3 to the strobe.
    en = 1'b1;
    wait_strobe(20, w);
    check("resume_latency", 32'(w), 32'(SDIV - 1 - 1 + 3));

    // 5. reset one cycle after a tick: the pending strobe is cancelled
    @(negedge clk);          // tick cycle T
    @(negedge clk);          // T+1
    rst = 1'b1;
    @(negedge clk);          // T+2
    rst = 1'b0;
    check("midrst_sv_t2", 32'(sample_valid), 32'd0);
    check("midrst_mag_t2", 32'(magnitude), 32'd1024);
    @(negedge clk);          // T+3
    check("midrst_sv_t3", 32'(sample_valid), 32'd0);
    check("midrst_mag_t3", 32'(magnitude), 32'd1024);
    check("midrst_addr", 32'(lut_addr), 32'd0);

    // 6. tune = 0: steady strobes, constant midscale + q(0)
    tune = 8'd0;
    wait_strobe(20, w);
    for (int k = 0; k < 3; k++) begin
      wait_strobe(20, w);
      check("tz_period", 32'(w), 32'(SDIV));
      check("tz_mag", 32'(magnitude), 32'd1024);
      check("tz_addr", 32'(lut_addr), 32'd0);
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
